ram_test_sequencer: RTL and testbench
=====================================

// Module: ram_test_sequencer
// PURPOSE
//  Sequences the RAM-test core over its AXI4-Lite cfg write port: programs BASE/END, then runs a fixed
//  6-step pattern table (INCR, ONES, ZERO; each as write-pass then read-pass) and tracks completion and errors.
//  Replaces the free-running index sequence in the top level. Drives the status LED and pass/fail outputs.
//  Sits between top-level control (start/loop) and fpga_top cfg_* / status_* on clk_w.
// PARAMETERS
//  BASE_ADDR    32'h0           first byte address tested; written to BASE (0x04)
//  END_ADDR     32'h2000_0000   end address (512 MiB); written to END (0x08)
//  BURST_LEN    4'd3            CFG[31:28] value, i.e. (16/4)-1
//  BUSY_WAIT    16              cycles allowed for status_busy_i to rise after a CFG write
//  TIMEOUT      32'hFFFF_FFFF   watchdog per step, in cycles; 0 disables the watchdog
// PORTS
//  clk_w          in   1   system clock
//  rst_w          in   1   asynchronous reset, active-high
//  start_i        in   1   pulse; launches a run from IDLE/PASS/FAIL, ignored while RUN
//  loop_i         in   1   1: restart the table after step 5 passes (sampled at step 5 done)
//  cfg_awvalid_o  out  1   AXI-Lite AW valid
//  cfg_awaddr_o   out  8   register offset (0x00 CFG, 0x04 BASE, 0x08 END)
//  cfg_awready_i  in   1   AW ready
//  cfg_wvalid_o   out  1   W valid (wstrb fixed 4'hF outside this block)
//  cfg_wdata_o    out  32  write data
//  cfg_wready_i   in   1   W ready
//  cfg_bvalid_i   in   1   B valid
//  cfg_bready_o   out  1   tied 1
//  status_busy_i  in   1   test core busy
//  status_err_i   in   1   test core compare error (sticky in core)
//  step_o         out  3   current table index 0..5
//  pass_count_o   out  16  completed full table passes; saturates at 16'hFFFF
//  running_o      out  1   1 while state is neither IDLE, PASS nor FAIL
//  pass_o         out  1   1 in PASS state
//  fail_o         out  1   1 in FAIL state
//  timeout_o      out  1   sticky; set when FAIL is caused by the watchdog
//  led_rgb_o      out  3   {r,g,b} registered, active-high: fail=100, running=001, pass/idle=010
// BEHAVIOUR
//  Reset: state IDLE; all valids 0; awaddr/wdata 0; step_o 0; pass_count_o 0; pass/fail/timeout/running 0;
//   led_rgb_o 3'b010. Reset mid-transaction drops AW/W valid immediately (asynchronous).
//  FSM: IDLE -start-> WR_BASE -> WR_END -> WR_CFG -> WAIT_BUSY -> WAIT_DONE -> (next WR_CFG | PASS | FAIL).
//   PASS/FAIL -start-> WR_BASE; a new run clears step, timeout_o and pass/fail; pass_count_o is kept.
//  Write txn (WR_*): awvalid and wvalid both rise in the first cycle of the state with stable addr/data.
//   Each valid drops the cycle after its own ready is sampled high. The txn completes on the first bvalid_i
//   seen after both are accepted; bresp is ignored. Next state is entered the cycle after bvalid.
//  CFG word: [31:28]=BURST_LEN, [8]=READ, [2]=INCR, [1]=ONES, [0]=ZERO; all other bits 0.
//   Step k: pattern = INCR (k=0,1), ONES (k=2,3), ZERO (k=4,5); READ = k[0].
//   Example: step1 = 32'h3000_0104.
//  WAIT_BUSY: counts up to BUSY_WAIT cycles. busy=1 goes to WAIT_DONE. Expiry with busy never seen counts as
//   step complete (instant test).
//  WAIT_DONE: busy=0 completes the step.
//   After step 5 completes: loop_i=1 increments pass_count and returns to WR_CFG with step 0;
//   loop_i=0 increments pass_count and goes to PASS.
//   Otherwise the block increments step and returns to WR_CFG.
//  status_err_i=1 in WAIT_BUSY or WAIT_DONE goes to FAIL the next cycle and takes priority over completion in
//   the same cycle. Errors outside these states are ignored. step_o freezes at the failing step.
//  Watchdog: a 32-bit counter clears on entry to each WR_CFG. When TIMEOUT!=0 and the counter reaches TIMEOUT
//   in any RUN state, the block goes to FAIL and sets timeout_o; any in-flight valids are dropped.
//  start_i during RUN is ignored. start_i and reset in the same cycle: reset wins.
//  led_rgb_o is registered one cycle after the state it reflects.
// STRUCTURE
//  Package ram_test_pkg: register offsets, CFG bit positions, state encoding, CFG word builder function.
//  Sub-module cfg_axil_wr_master: single-outstanding AXI-Lite write (req/addr/data in, done pulse out).
//  Top of this block holds the FSM, step/pass counters, watchdog and LED register.
// TESTING
//  1 Reset, start pulse, ideal slave (ready=1, bvalid 1 cycle later) -> writes in order 0x04=0, 0x08=0x2000_0000,
//    0x00=0x3000_0004; step_o=0.
//  2 AW ready 3 cycles before W ready, B 2 cycles later -> each valid drops individually; exactly one txn per
//    register; no re-issue.
//  3 Busy model 50 cycles per step, loop_i=0 -> six CFG words 3000_0004, 3000_0104, 3000_0002, 3000_0102,
//    3000_0001, 3000_0101; then pass_o=1, pass_count_o=1, led=010.
//  4 status_err_i raised during step 3 WAIT_DONE -> fail_o=1 next cycle, step_o=3, led=100; later start -> BASE
//    write reissued.
//  5 Busy never rises -> each step completes after BUSY_WAIT=16 cycles. TIMEOUT=1000 with busy stuck at 1 ->
//    FAIL and timeout_o=1 at cycle 1000.
//  6 loop_i=1 for 3 passes, then rst_w asserted mid-AW -> pass_count_o=3 before reset; after reset all outputs
//    at reset values and valids low.

Source files
------------

// File: rtl/ram_test_pkg.sv
// Shared constants, FSM encoding and CFG word builder for the RAM-test sequencer.
package ram_test_pkg;

  // Register offsets of the RAM-test core cfg port
  localparam logic [7:0] RegCfg  = 8'h00;
  localparam logic [7:0] RegBase = 8'h04;
  localparam logic [7:0] RegEnd  = 8'h08;

  // CFG word bit positions
  localparam int unsigned CfgBurstLsb = 28;
  localparam int unsigned CfgReadBit  = 8;
  localparam int unsigned CfgIncrBit  = 2;
  localparam int unsigned CfgOnesBit  = 1;
  localparam int unsigned CfgZeroBit  = 0;

  localparam logic [2:0] LastStep = 3'd5;

  // {r,g,b}
  localparam logic [2:0] LedFail = 3'b100;
  localparam logic [2:0] LedRun  = 3'b001;
  localparam logic [2:0] LedIdle = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StWrBase,
    StWrEnd,
    StWrCfg,
    StWaitBusy,
    StWaitDone,
    StPass,
    StFail
  } seq_state_e;

  // Table step -> CFG word: pairs of (write, read) passes over INCR, ONES, ZERO
  function automatic logic [31:0] cfg_word(input logic [2:0] step, input logic [3:0] burst);
    logic [31:0] w;
    w = '0;
    w[CfgBurstLsb +: 4] = burst;
    w[CfgReadBit]       = step[0];
    if (step < 3'd2) begin
      w[CfgIncrBit] = 1'b1;
    end else if (step < 3'd4) begin
      w[CfgOnesBit] = 1'b1;
    end else begin
      w[CfgZeroBit] = 1'b1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ram_test_sequencer_cfg_axil_wr_master.sv
// Single-outstanding AXI4-Lite write master. The caller holds req_i (with stable addr/data) for
// the whole transaction; valids follow req_i combinationally so they rise in the first cycle.
module cfg_axil_wr_master (
  input  logic        clk_w,
  input  logic        rst_w,
  input  logic        req_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] data_i,
  output logic        awvalid_o,
  output logic [7:0]  awaddr_o,
  input  logic        awready_i,
  output logic        wvalid_o,
  output logic [31:0] wdata_o,
  input  logic        wready_i,
  input  logic        bvalid_i,
  output logic        bready_o,
  output logic        done_o
);

  logic aw_acc_q;
  logic w_acc_q;

  assign awvalid_o = req_i & ~aw_acc_q;
  assign wvalid_o  = req_i & ~w_acc_q;
  assign awaddr_o  = addr_i;
  assign wdata_o   = data_i;
  assign bready_o  = 1'b1;
  // B only counts once both channels have been accepted in earlier cycles
  assign done_o    = req_i & aw_acc_q & w_acc_q & bvalid_i;

  // Track per-channel acceptance; dropping req_i abandons the transaction
  always_ff @(posedge clk_w or posedge rst_w) begin
    if (rst_w) begin
      aw_acc_q <= 1'b0;
      w_acc_q  <= 1'b0;
    end else if (!req_i || done_o) begin
      aw_acc_q <= 1'b0;
      w_acc_q  <= 1'b0;
    end else begin
      if (awvalid_o && awready_i) aw_acc_q <= 1'b1;
      if (wvalid_o && wready_i)   w_acc_q  <= 1'b1;
    end
  end

endmodule

// File: rtl/ram_test_sequencer.sv
// Programs BASE/END then walks the six-step pattern table on the RAM-test core, with watchdog,
// pass counting and status LED.
module ram_test_sequencer
  import ram_test_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] END_ADDR  = 32'h2000_0000,
  parameter logic [3:0]  BURST_LEN = 4'd3,
  parameter int unsigned BUSY_WAIT = 16,
  parameter logic [31:0] TIMEOUT   = 32'hFFFF_FFFF
) (
  input  logic        clk_w,
  input  logic        rst_w,
  input  logic        start_i,
  input  logic        loop_i,
  output logic        cfg_awvalid_o,
  output logic [7:0]  cfg_awaddr_o,
  input  logic        cfg_awready_i,
  output logic        cfg_wvalid_o,
  output logic [31:0] cfg_wdata_o,
  input  logic        cfg_wready_i,
  input  logic        cfg_bvalid_i,
  output logic        cfg_bready_o,
  input  logic        status_busy_i,
  input  logic        status_err_i,
  output logic [2:0]  step_o,
  output logic [15:0] pass_count_o,
  output logic        running_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic [2:0]  led_rgb_o
);

  seq_state_e  state_q;
  logic [2:0]  step_q;
  logic [15:0] pass_cnt_q;
  logic        timeout_q;
  logic [15:0] busy_cnt_q;
  logic [31:0] wdog_q;
  logic [2:0]  led_q;

  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_done;
  logic        wait_st;
  logic        wdog_hit;
  logic        step_done;
  logic [2:0]  led_next;

  // Write request, address and data decoded from the current state
  always_comb begin
    wr_req  = 1'b1;
    wr_addr = RegCfg;
    wr_data = cfg_word(step_q, BURST_LEN);
    unique case (state_q)
      StWrBase: begin
        wr_addr = RegBase;
        wr_data = BASE_ADDR;
      end
      StWrEnd: begin
        wr_addr = RegEnd;
        wr_data = END_ADDR;
      end
      StWrCfg: ;
      default: begin
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
      end
    endcase
  end

  cfg_axil_wr_master u_wr_master (
    .clk_w     (clk_w),
    .rst_w     (rst_w),
    .req_i     (wr_req),
    .addr_i    (wr_addr),
    .data_i    (wr_data),
    .awvalid_o (cfg_awvalid_o),
    .awaddr_o  (cfg_awaddr_o),
    .awready_i (cfg_awready_i),
    .wvalid_o  (cfg_wvalid_o),
    .wdata_o   (cfg_wdata_o),
    .wready_i  (cfg_wready_i),
    .bvalid_i  (cfg_bvalid_i),
    .bready_o  (cfg_bready_o),
    .done_o    (wr_done)
  );

  // Step-completion and watchdog conditions plus LED colour for the current state
  always_comb begin
    wait_st   = (state_q == StWaitBusy) || (state_q == StWaitDone);
    wdog_hit  = (TIMEOUT != 32'd0) && (wdog_q == TIMEOUT - 32'd1);
    // Busy never seen within the window is treated as an instant test
    step_done = ((state_q == StWaitBusy) && !status_busy_i &&
                 (busy_cnt_q == 16'(BUSY_WAIT - 1))) ||
                ((state_q == StWaitDone) && !status_busy_i);
    if (state_q == StFail) begin
      led_next = LedFail;
    end else if (running_o) begin
      led_next = LedRun;
    end else begin
      led_next = LedIdle;
    end
  end

  assign running_o    = (state_q != StIdle) && (state_q != StPass) && (state_q != StFail);
  assign pass_o       = (state_q == StPass);
  assign fail_o       = (state_q == StFail);
  assign step_o       = step_q;
  assign pass_count_o = pass_cnt_q;
  assign timeout_o    = timeout_q;
  assign led_rgb_o    = led_q;

  // Sequencer FSM with step/pass counters, watchdog and LED register
  always_ff @(posedge clk_w or posedge rst_w) begin
    if (rst_w) begin
      state_q    <= StIdle;
      step_q     <= '0;
      pass_cnt_q <= '0;
      timeout_q  <= 1'b0;
      busy_cnt_q <= '0;
      wdog_q     <= '0;
      led_q      <= LedIdle;
    end else begin
      led_q <= led_next;
      unique case (state_q)
        StIdle, StPass, StFail: begin
          if (start_i) begin
            state_q   <= StWrBase;
            step_q    <= '0;
            timeout_q <= 1'b0;
            wdog_q    <= '0;
          end
        end
        default: begin
          wdog_q <= wdog_q + 32'd1;
          // Error beats watchdog, watchdog beats completion
          if (wait_st && status_err_i) begin
            state_q <= StFail;
          end else if (wdog_hit) begin
            state_q   <= StFail;
            timeout_q <= 1'b1;
          end else if (step_done) begin
            if (step_q == LastStep) begin
              if (pass_cnt_q != 16'hFFFF) pass_cnt_q <= pass_cnt_q + 16'd1;
              if (loop_i) begin
                step_q  <= '0;
                state_q <= StWrCfg;
                wdog_q  <= '0;
              end else begin
                state_q <= StPass;
              end
            end else begin
              step_q  <= step_q + 3'd1;
              state_q <= StWrCfg;
              wdog_q  <= '0;
            end
          end else begin
            case (state_q)
              StWrBase: if (wr_done) state_q <= StWrEnd;
              StWrEnd: begin
                if (wr_done) begin
                  state_q <= StWrCfg;
                  wdog_q  <= '0;
                end
              end
              StWrCfg: begin
                if (wr_done) begin
                  state_q    <= StWaitBusy;
                  busy_cnt_q <= '0;
                end
              end
              StWaitBusy: begin
                if (status_busy_i) state_q <= StWaitDone;
                else               busy_cnt_q <= busy_cnt_q + 16'd1;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_test_sequencer.sv
// Directed bench for ram_test_sequencer with a negedge-driven AXI-Lite slave and busy model.
module tb_ram_test_sequencer;

  logic        clk_w = 1'b0;
  logic        rst_w = 1'b1;
  logic        start_i = 1'b0;
  logic        loop_i = 1'b0;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [7:0]  awaddr;
  logic [31:0] wdata;
  logic        status_busy, status_err;
  logic [2:0]  step;
  logic [15:0] pass_count;
  logic        running, pass, fail, timeout;
  logic [2:0]  led;

  int checks = 0;
  int failures = 0;

  // Slave knobs (written by the main sequence only)
  int aw_lat = 0, w_lat = 0, b_lat = 0, busy_len = 0;
  logic busy_stuck = 1'b0;

  // Slave state (written by the slave process only)
  logic [7:0]  aw_log[$];
  logic [31:0] w_log[$];
  int aw_ctr, w_ctr, b_ctr, busy_ctr, reissue;
  logic aw_got, w_got, cur_cfg, split_seen;

  always #5 clk_w = ~clk_w;

  ram_test_sequencer #(
    .BUSY_WAIT (16),
    .TIMEOUT   (32'd1000)
  ) dut (
    .clk_w         (clk_w),
    .rst_w         (rst_w),
    .start_i       (start_i),
    .loop_i        (loop_i),
    .cfg_awvalid_o (awvalid),
    .cfg_awaddr_o  (awaddr),
    .cfg_awready_i (awready),
    .cfg_wvalid_o  (wvalid),
    .cfg_wdata_o   (wdata),
    .cfg_wready_i  (wready),
    .cfg_bvalid_i  (bvalid),
    .cfg_bready_o  (bready),
    .status_busy_i (status_busy),
    .status_err_i  (status_err),
    .step_o        (step),
    .pass_count_o  (pass_count),
    .running_o     (running),
    .pass_o        (pass),
    .fail_o        (fail),
    .timeout_o     (timeout),
    .led_rgb_o     (led)
  );

  // AXI-Lite slave and busy model, acting on the falling edge
  initial begin
    awready = 0; wready = 0; bvalid = 0; status_busy = 0;
    aw_ctr = 0; w_ctr = 0; b_ctr = 0; busy_ctr = 0; reissue = 0;
    aw_got = 0; w_got = 0; cur_cfg = 0; split_seen = 0;
    forever begin
      @(negedge clk_w);
      if (rst_w) begin
        awready = 0; wready = 0; bvalid = 0; status_busy = 0;
        aw_ctr = 0; w_ctr = 0; b_ctr = 0; busy_ctr = 0; reissue = 0;
        aw_got = 0; w_got = 0; cur_cfg = 0; split_seen = 0;
        aw_log.delete();
        w_log.delete();
      end else begin
        if (bvalid) begin
          bvalid = 0; aw_got = 0; w_got = 0; b_ctr = 0;
          if (cur_cfg) busy_ctr = busy_len;
        end else if (aw_got && w_got) begin
          if (b_ctr >= b_lat) bvalid = 1;
          else b_ctr++;
        end
        if (awvalid && aw_got) reissue++;
        if (wvalid && w_got) reissue++;
        if (wvalid && !awvalid) split_seen = 1;
        if (awvalid && !aw_got) begin
          if (aw_ctr >= aw_lat) awready = 1;
          else begin awready = 0; aw_ctr++; end
        end else begin
          awready = 0; aw_ctr = 0;
        end
        if (wvalid && !w_got) begin
          if (w_ctr >= w_lat) wready = 1;
          else begin wready = 0; w_ctr++; end
        end else begin
          wready = 0; w_ctr = 0;
        end
        if (busy_ctr > 0) begin status_busy = 1; busy_ctr--; end
        else status_busy = busy_stuck;
        #1;
        if (awvalid && awready) begin
          aw_log.push_back(awaddr); aw_got = 1; cur_cfg = (awaddr == 8'h00);
        end
        if (wvalid && wready) begin
          w_log.push_back(wdata); w_got = 1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic do_reset();
    @(negedge clk_w);
    rst_w = 1; start_i = 0; loop_i = 0; status_err = 0;
    aw_lat = 0; w_lat = 0; b_lat = 0; busy_len = 0; busy_stuck = 0;
    repeat (2) @(negedge clk_w);
    rst_w = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk_w);
    start_i = 1;
    @(negedge clk_w);
    start_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({awvalid, wvalid, awaddr, wdata} !== 42'd0) begin
      failures++;
      $display("FAIL reset_bus: got %0h expected 0", {awvalid, wvalid, awaddr, wdata});
    end
    checks++;
    if ({step, pass_count, running, pass, fail, timeout} !== 23'd0) begin
      failures++;
      $display("FAIL reset_status: got %0h expected 0",
               {step, pass_count, running, pass, fail, timeout});
    end
    checks++;
    if (led !== 3'b010 || bready !== 1'b1) begin
      failures++;
      $display("FAIL reset_led_bready: got %b/%b expected 010/1", led, bready);
    end
  endtask

  task automatic test_write_order();
    logic [7:0]  exp_a[3];
    logic [31:0] exp_d[3];
    int i;
    exp_a = '{8'h04, 8'h08, 8'h00};
    exp_d = '{32'h0, 32'h2000_0000, 32'h3000_0004};
    do_reset();
    busy_stuck = 1;
    pulse_start();
    checks++;
    if (!(running === 1'b1 && awvalid === 1'b1 && wvalid === 1'b1 && awaddr === 8'h04)) begin
      failures++;
      $display("FAIL first_cycle_valids: got run=%b aw=%b w=%b addr=%0h expected 1 1 1 4",
               running, awvalid, wvalid, awaddr);
    end
    for (i = 0; i < 100 && w_log.size() < 3; i++) @(negedge clk_w);
    checks++;
    if (aw_log.size() < 3 || w_log.size() < 3) begin
      failures++;
      $display("FAIL order_count: got %0d/%0d expected 3/3", aw_log.size(), w_log.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (aw_log[k] !== exp_a[k] || w_log[k] !== exp_d[k]) begin
          failures++;
          $display("FAIL order_%0d: got %0h=%0h expected %0h=%0h",
                   k, aw_log[k], w_log[k], exp_a[k], exp_d[k]);
        end
      end
    end
    checks++;
    if (step !== 3'd0 || led !== 3'b001) begin
      failures++;
      $display("FAIL order_step_led: got %0d/%b expected 0/001", step, led);
    end
  endtask

  task automatic test_split_handshake();
    do_reset();
    aw_lat = 0; w_lat = 3; b_lat = 1; busy_stuck = 1;
    pulse_start();
    repeat (60) @(negedge clk_w);
    checks++;
    if (aw_log.size() != 3 || w_log.size() != 3) begin
      failures++;
      $display("FAIL split_txn_count: got %0d/%0d expected 3/3", aw_log.size(), w_log.size());
    end
    checks++;
    if (reissue != 0) begin
      failures++;
      $display("FAIL split_reissue: got %0d expected 0", reissue);
    end
    checks++;
    if (split_seen !== 1'b1) begin
      failures++;
      $display("FAIL split_aw_drop: got %b expected 1", split_seen);
    end
    checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0 || running !== 1'b1) begin
      failures++;
      $display("FAIL split_idle_bus: got %b%b%b expected 001", awvalid, wvalid, running);
    end
  endtask

  task automatic test_full_pass();
    logic [31:0] exp_cfg[6];
    logic [31:0] got_cfg[$];
    int i;
    exp_cfg = '{32'h3000_0004, 32'h3000_0104, 32'h3000_0002,
                32'h3000_0102, 32'h3000_0001, 32'h3000_0101};
    do_reset();
    busy_len = 50;
    pulse_start();
    for (i = 0; i < 3000 && !pass; i++) @(negedge clk_w);
    checks++;
    if (pass !== 1'b1) begin
      failures++;
      $display("FAIL pass_reached: got %b expected 1", pass);
    end
    for (int k = 0; k < aw_log.size() && k < w_log.size(); k++)
      if (aw_log[k] == 8'h00) got_cfg.push_back(w_log[k]);
    checks++;
    if (got_cfg.size() != 6) begin
      failures++;
      $display("FAIL cfg_count: got %0d expected 6", got_cfg.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (got_cfg[k] !== exp_cfg[k]) begin
          failures++;
          $display("FAIL cfg_word_%0d: got %h expected %h", k, got_cfg[k], exp_cfg[k]);
        end
      end
    end
    @(negedge clk_w);
    checks++;
    if (pass_count !== 16'd1 || led !== 3'b010 || running !== 1'b0 || fail !== 1'b0) begin
      failures++;
      $display("FAIL pass_status: got cnt=%0d led=%b run=%b fail=%b expected 1 010 0 0",
               pass_count, led, running, fail);
    end
  endtask

  task automatic test_error();
    int i;
    do_reset();
    busy_len = 50;
    pulse_start();
    for (i = 0; i < 2000 && !(step == 3'd3 && status_busy); i++) @(negedge clk_w);
    repeat (5) @(negedge clk_w);
    checks++;
    if (fail !== 1'b0 || step !== 3'd3) begin
      failures++;
      $display("FAIL err_pre: got fail=%b step=%0d expected 0 3", fail, step);
    end
    status_err = 1;
    @(negedge clk_w);
    status_err = 0;
    checks++;
    if (fail !== 1'b1 || step !== 3'd3 || timeout !== 1'b0 || led !== 3'b001) begin
      failures++;
      $display("FAIL err_fail: got fail=%b step=%0d to=%b led=%b expected 1 3 0 001",
               fail, step, timeout, led);
    end
    @(negedge clk_w);
    checks++;
    if (led !== 3'b100) begin
      failures++;
      $display("FAIL err_led: got %b expected 100", led);
    end
    pulse_start();
    checks++;
    if (awvalid !== 1'b1 || awaddr !== 8'h04 || fail !== 1'b0 || step !== 3'd0) begin
      failures++;
      $display("FAIL err_restart: got aw=%b addr=%0h fail=%b step=%0d expected 1 4 0 0",
               awvalid, awaddr, fail, step);
    end
    // Error during a register write is ignored
    status_err = 1;
    @(negedge clk_w);
    status_err = 0;
    checks++;
    if (fail !== 1'b0 || running !== 1'b1) begin
      failures++;
      $display("FAIL err_ignored_in_write: got fail=%b run=%b expected 0 1", fail, running);
    end
  endtask

  task automatic test_instant_and_watchdog();
    int n;
    int i;
    logic prev;
    do_reset();
    pulse_start();
    for (i = 0; i < 100 && !(awvalid && awaddr == 8'h00); i++) @(negedge clk_w);
    n = 0;
    prev = 1;
    for (i = 0; i < 100; i++) begin
      @(negedge clk_w);
      n++;
      if (awvalid && awaddr == 8'h00 && !prev) break;
      prev = awvalid && (awaddr == 8'h00);
    end
    checks++;
    if (n != 18) begin
      failures++;
      $display("FAIL instant_step_period: got %0d expected 18", n);
    end
    for (i = 0; i < 500 && !pass; i++) @(negedge clk_w);
    checks++;
    if (pass !== 1'b1 || pass_count !== 16'd1) begin
      failures++;
      $display("FAIL instant_pass: got pass=%b cnt=%0d expected 1 1", pass, pass_count);
    end

    do_reset();
    busy_stuck = 1;
    pulse_start();
    for (i = 0; i < 100 && !(awvalid && awaddr == 8'h00); i++) @(negedge clk_w);
    n = 0;
    for (i = 0; i < 1200 && !fail; i++) begin
      @(negedge clk_w);
      n++;
    end
    checks++;
    if (n != 1000) begin
      failures++;
      $display("FAIL watchdog_cycles: got %0d expected 1000", n);
    end
    checks++;
    if (timeout !== 1'b1 || fail !== 1'b1 || step !== 3'd0 || awvalid !== 1'b0) begin
      failures++;
      $display("FAIL watchdog_status: got to=%b fail=%b step=%0d aw=%b expected 1 1 0 0",
               timeout, fail, step, awvalid);
    end
    pulse_start();
    checks++;
    if (timeout !== 1'b0 || fail !== 1'b0) begin
      failures++;
      $display("FAIL watchdog_clear: got to=%b fail=%b expected 0 0", timeout, fail);
    end
  endtask

  task automatic test_loop_and_reset();
    int i;
    do_reset();
    loop_i = 1; busy_len = 3; aw_lat = 4;
    pulse_start();
    for (i = 0; i < 5000 && pass_count != 16'd3; i++) @(negedge clk_w);
    checks++;
    if (pass_count !== 16'd3 || running !== 1'b1 || pass !== 1'b0) begin
      failures++;
      $display("FAIL loop_count: got cnt=%0d run=%b pass=%b expected 3 1 0",
               pass_count, running, pass);
    end
    checks++;
    if (awvalid !== 1'b1 || awaddr !== 8'h00 || wdata !== 32'h3000_0004 || step !== 3'd0) begin
      failures++;
      $display("FAIL loop_restart_cfg: got aw=%b addr=%0h data=%h step=%0d expected 1 0 30000004 0",
               awvalid, awaddr, wdata, step);
    end
    rst_w = 1;
    #1;
    checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0 || awaddr !== 8'h00 || wdata !== 32'h0) begin
      failures++;
      $display("FAIL async_reset_bus: got %b%b %0h %0h expected 00 0 0",
               awvalid, wvalid, awaddr, wdata);
    end
    checks++;
    if ({step, pass_count, running, pass, fail, timeout} !== 23'd0 || led !== 3'b010) begin
      failures++;
      $display("FAIL async_reset_status: got %0h led=%b expected 0 010",
               {step, pass_count, running, pass, fail, timeout}, led);
    end
    @(negedge clk_w);
    rst_w = 0;
    loop_i = 0;
  endtask

  initial begin
    status_err = 0;
    test_reset();
    test_write_order();
    test_split_handshake();
    test_full_pass();
    test_error();
    test_instant_and_watchdog();
    test_loop_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
